ring_token_arbiter: RTL and testbench
=====================================

RING_TOKEN_ARBITER -- requirements
Module: ring_token_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUESTERS, default 8, giving the number of requesters and the token ring width.
REQ-002 SHALL have parameter SLOT_WIDTH, default 8, giving the grant-duration counter width.
REQ-003 SHALL have port Clk_In  input  1  single clock; all state updates on the falling edge.
REQ-004 SHALL have port Reset_In  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Enable_In  input  1  output enable; when low, all outputs are high-impedance and internal state continues.
REQ-006 SHALL have port Start_Arbiter_Command_In  input  1  sets the running flag.
REQ-007 SHALL have port Stop_Arbiter_Command_In  input  1  clears the running flag.
REQ-008 SHALL have port Request_In  input  NUM_REQUESTERS  level request per requester; deassertion while granted means release.
REQ-009 SHALL have port Slot_Limit_In  input  SLOT_WIDTH  maximum grant length in cycles; 0 means unlimited.
REQ-010 SHALL have port Grant_Out  output  NUM_REQUESTERS  one-hot grant, or all zeros.
REQ-011 SHALL have port Token_Out  output  NUM_REQUESTERS  current one-hot ring token position.
REQ-012 SHALL have port Arbiter_Running_Flag_Out  output  1  running flag.
REQ-013 SHALL have port Timeout_Flag_Out  output  1  one-cycle pulse when a grant is ended by the slot limit.

Function
REQ-014 The running flag SHALL be set by Start and cleared by Stop; Start SHALL win when both are asserted at the same edge.
REQ-015 The FSM SHALL have exactly four states: IDLE, SCAN, GRANT, GAP.
REQ-016 IDLE: Grant_Out is 0 and the token holds; the FSM SHALL go to SCAN at the first edge where the running flag is 1.
REQ-017 SCAN, when (Request_In & token) is nonzero: the FSM SHALL go to GRANT and load Grant_Out with the token and the slot counter with 1 at that same edge.
REQ-018 SCAN, when (Request_In & token) is zero: the token SHALL rotate one position per cycle (bit i to bit i+1, MSB wraps to bit 0); worst-case request-to-grant latency is NUM_REQUESTERS cycles.
REQ-019 GRANT: the token SHALL hold and the slot counter SHALL increment each cycle, saturating at its maximum.
REQ-020 GRANT release: when the granted Request_In bit is 0, the FSM SHALL exit to GAP at the next edge.
REQ-021 GRANT timeout: when Slot_Limit_In is nonzero and the counter equals Slot_Limit_In, the FSM SHALL exit to GAP and pulse Timeout_Flag_Out for one cycle.
REQ-022 When release and timeout coincide, release SHALL take precedence and no timeout pulse SHALL be issued.
REQ-023 GAP SHALL last exactly one cycle with Grant_Out 0, and the token SHALL rotate one position so the same requester cannot be re-granted back-to-back.
REQ-024 After GAP, the FSM SHALL go to SCAN if the running flag is 1, otherwise to IDLE.
REQ-025 Stop during SCAN SHALL take the FSM to IDLE at the next edge with the token held; Stop during GRANT SHALL NOT truncate the grant (graceful stop via GAP).
REQ-026 Grant_Out SHALL never have more than one bit set, and SHALL only be nonzero in GRANT.
REQ-027 Slot_Limit_In SHALL be sampled every GRANT cycle; a change mid-grant takes effect immediately.

Reset
REQ-028 Reset_In high SHALL immediately force: FSM IDLE, token 1 (bit 0), Grant_Out 0, running flag 0, slot counter 0, Timeout_Flag_Out 0.
REQ-029 Reset mid-grant SHALL drop the grant asynchronously; no GAP cycle and no timeout pulse SHALL follow.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (2-bit localparams IDLE=0, SCAN=1, GRANT=2, GAP=3) and the default widths.
REQ-031 The one-hot rotator SHALL be a sub-module, ring_token_register, with inputs Advance_In and Reset_In, reset value 1, and hold when not advancing.

Verification
REQ-032 Reset, Start, Request_In=8'h01: Grant_Out=8'h01 after the first SCAN edge; Token_Out=8'h01.
REQ-033 Token=8'h01, Request_In=8'h80: seven SCAN rotations, then Grant_Out=8'h80; next GAP wraps Token_Out to 8'h01.
REQ-034 Slot_Limit_In=4, Request_In=8'h04 held: Grant_Out=8'h04 for 4 cycles, then Timeout_Flag_Out pulses once, 1 GAP cycle, and Token_Out moves to 8'h08.
REQ-035 Request_In=8'hFF held, Slot_Limit_In=2: grants rotate 01,02,04,...,80,01, each 2 cycles with a 1-cycle gap, and are never back-to-back to the same requester.
REQ-036 Stop asserted mid-grant: the grant completes on release, then GAP, then IDLE, and Arbiter_Running_Flag_Out=0; Start together with Stop sets the flag to 1.
REQ-037 Reset pulse during GRANT: Grant_Out=0 immediately and Token_Out=8'h01; Enable_In=0 puts all outputs at Z while the state still advances.

Source files
------------

// File: rtl/ring_token_arbiter_pkg.sv
// Shared FSM state encoding and default widths for the ring token arbiter.
// Combinational only; no latency or backpressure.
package ring_token_arbiter_pkg;

  localparam int DEFAULT_NUM_REQUESTERS = 8;
  localparam int DEFAULT_SLOT_WIDTH     = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] GRANT = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_SCAN  = SCAN,
    ST_GRANT = GRANT,
    ST_GAP   = GAP
  } arb_state_t;

endpackage

// File: rtl/ring_token_arbiter_if.sv
// Request/command bundle into the arbiter; the arbiter is the slave side.
// Pure wiring: no latency, no backpressure (levels sampled every falling edge).
interface ring_token_arbiter_if
  import ring_token_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = DEFAULT_NUM_REQUESTERS,
  parameter int SLOT_WIDTH     = DEFAULT_SLOT_WIDTH
);

  logic                      Enable_In;
  logic                      Start_Arbiter_Command_In;
  logic                      Stop_Arbiter_Command_In;
  logic [NUM_REQUESTERS-1:0] Request_In;
  logic [SLOT_WIDTH-1:0]     Slot_Limit_In;

  modport master (
    output Enable_In, Start_Arbiter_Command_In, Stop_Arbiter_Command_In,
           Request_In, Slot_Limit_In
  );

  modport slave (
    input  Enable_In, Start_Arbiter_Command_In, Stop_Arbiter_Command_In,
           Request_In, Slot_Limit_In
  );

endinterface

// File: rtl/ring_token_register.sv
// One-hot rotating token; rotates bit i to bit i+1 (MSB wraps) on Advance_In.
// One falling-edge cycle per advance; holds otherwise, no backpressure.
module ring_token_register #(
  parameter int WIDTH = 8
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic             Advance_In,
  output logic [WIDTH-1:0] Token_Out
);

  always_ff @(negedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      Token_Out <= WIDTH'(1);
    end else if (Advance_In) begin
      Token_Out <= {Token_Out[WIDTH-2:0], Token_Out[WIDTH-1]};
    end
  end

endmodule

// File: rtl/ring_token_arbiter.sv
// Token-ring arbiter: grant follows a rotating one-hot token, bounded by a slot limit.
// Request-to-grant up to NUM_REQUESTERS cycles; release/timeout always inserts one GAP cycle.
module ring_token_arbiter
  import ring_token_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = DEFAULT_NUM_REQUESTERS,
  parameter int SLOT_WIDTH     = DEFAULT_SLOT_WIDTH
) (
  input  logic                       Clk_In,
  input  logic                       Reset_In,
  ring_token_arbiter_if.slave        arb_if,
  output wire  [NUM_REQUESTERS-1:0]  Grant_Out,
  output wire  [NUM_REQUESTERS-1:0]  Token_Out,
  output wire                        Arbiter_Running_Flag_Out,
  output wire                        Timeout_Flag_Out
);

  arb_state_t                state_q, state_d;
  logic                      run_q, run_d;
  logic                      timeout_q, timeout_d;
  logic [SLOT_WIDTH-1:0]     slot_cnt_q, slot_cnt_d;
  logic                      advance;
  logic                      token_hit;
  logic                      slot_expired;
  logic [NUM_REQUESTERS-1:0] token;
  logic [NUM_REQUESTERS-1:0] grant;

  ring_token_register #(
    .WIDTH (NUM_REQUESTERS)
  ) u_token (
    .Clk_In     (Clk_In),
    .Reset_In   (Reset_In),
    .Advance_In (advance),
    .Token_Out  (token)
  );

  // In GRANT the token holds, so token & request also tells whether the holder still requests.
  assign token_hit    = |(arb_if.Request_In & token);
  assign slot_expired = (arb_if.Slot_Limit_In != '0) && (slot_cnt_q == arb_if.Slot_Limit_In);
  assign grant        = (state_q == ST_GRANT) ? token : '0;

  always_comb begin
    run_d      = run_q;
    state_d    = state_q;
    slot_cnt_d = slot_cnt_q;
    timeout_d  = 1'b0;
    advance    = 1'b0;

    if (arb_if.Start_Arbiter_Command_In) begin
      run_d = 1'b1;
    end else if (arb_if.Stop_Arbiter_Command_In) begin
      run_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (run_q) begin
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!run_d) begin
          state_d = ST_IDLE;
        end else if (token_hit) begin
          state_d    = ST_GRANT;
          slot_cnt_d = SLOT_WIDTH'(1);
        end else begin
          advance = 1'b1;
        end
      end
      ST_GRANT: begin
        // Release outranks timeout, so a coinciding release never pulses the flag.
        if (!token_hit) begin
          state_d = ST_GAP;
        end else if (slot_expired) begin
          state_d   = ST_GAP;
          timeout_d = 1'b1;
        end else if (slot_cnt_q != '1) begin
          slot_cnt_d = slot_cnt_q + SLOT_WIDTH'(1);
        end
      end
      ST_GAP: begin
        advance    = 1'b1;
        slot_cnt_d = '0;
        state_d    = run_q ? ST_SCAN : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(negedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q    <= ST_IDLE;
      run_q      <= 1'b0;
      timeout_q  <= 1'b0;
      slot_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      timeout_q  <= timeout_d;
      slot_cnt_q <= slot_cnt_d;
    end
  end

  assign Grant_Out                = arb_if.Enable_In ? grant     : 'z;
  assign Token_Out                = arb_if.Enable_In ? token     : 'z;
  assign Arbiter_Running_Flag_Out = arb_if.Enable_In ? run_q     : 1'bz;
  assign Timeout_Flag_Out         = arb_if.Enable_In ? timeout_q : 1'bz;

endmodule

// File: tb/tb_ring_token_arbiter.sv
// Scoreboarded bench for ring_token_arbiter: expectations queued per cycle, checked on rising edges.
module tb_ring_token_arbiter;

  typedef struct packed {
    logic [7:0] grant;
    logic [7:0] token;
    logic       tmo;
    logic       run;
  } exp_t;

  logic clk;
  logic rst;
  wire  [7:0] grant_w;
  wire  [7:0] token_w;
  wire        run_w;
  wire        tmo_w;

  int vectors;
  int miscompares;

  exp_t  exp_q[$];
  string tag_q[$];

  ring_token_arbiter_if arb_if ();

  ring_token_arbiter dut (
    .Clk_In                   (clk),
    .Reset_In                 (rst),
    .arb_if                   (arb_if),
    .Grant_Out                (grant_w),
    .Token_Out                (token_w),
    .Arbiter_Running_Flag_Out (run_w),
    .Timeout_Flag_Out         (tmo_w)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h required %h", tag, got, exp);
    end
  endtask

  // State is updated on falling edges; rising edges are the quiet sampling point.
  always @(posedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_vec({t, ".grant"}, 32'(grant_w), 32'(e.grant));
      check_vec({t, ".token"}, 32'(token_w), 32'(e.token));
      check_vec({t, ".tmo"},   32'(tmo_w),   32'(e.tmo));
      check_vec({t, ".run"},   32'(run_w),   32'(e.run));
    end
  end

  // Queue what the outputs must be after the coming falling edge, then move past the next rising edge.
  task automatic step(input string tag, input logic [7:0] g, input logic [7:0] t,
                      input logic tmo, input logic run);
    exp_t e;
    e.grant = g;
    e.token = t;
    e.tmo   = tmo;
    e.run   = run;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    arb_if.Start_Arbiter_Command_In = 1'b0;
    arb_if.Stop_Arbiter_Command_In  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Leaves the FSM in SCAN with the token at bit 0.
  task automatic do_start();
    arb_if.Start_Arbiter_Command_In = 1'b1;
    step("start_idle", 8'h00, 8'h01, 1'b0, 1'b1);
    arb_if.Start_Arbiter_Command_In = 1'b0;
    step("start_scan", 8'h00, 8'h01, 1'b0, 1'b1);
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  function automatic logic is_hiz8(input logic [7:0] v);
    return (v === 8'hzz) || (v === 8'h00);
  endfunction

  initial begin
    logic [7:0] t;
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    arb_if.Enable_In                = 1'b1;
    arb_if.Start_Arbiter_Command_In = 1'b0;
    arb_if.Stop_Arbiter_Command_In  = 1'b0;
    arb_if.Request_In               = 8'h00;
    arb_if.Slot_Limit_In            = 8'd0;
    #2;
    check_vec("rst.grant", 32'(grant_w), 32'h00);
    check_vec("rst.token", 32'(token_w), 32'h01);
    check_vec("rst.run",   32'(run_w),   32'h0);
    check_vec("rst.tmo",   32'(tmo_w),   32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First requester granted straight out of the first SCAN cycle.
    arb_if.Request_In = 8'h01;
    do_start();
    step("t1_grant", 8'h01, 8'h01, 1'b0, 1'b1);
    step("t1_hold",  8'h01, 8'h01, 1'b0, 1'b1);
    arb_if.Request_In = 8'h00;
    step("t1_gap",   8'h00, 8'h01, 1'b0, 1'b1);
    step("t1_scan",  8'h00, 8'h02, 1'b0, 1'b1);

    // Worst-case latency: token walks all the way to the MSB, then wraps after GAP.
    do_reset();
    arb_if.Request_In = 8'h80;
    do_start();
    for (int i = 1; i < 8; i++) begin
      t = 8'h01 << i;
      step("t2_rotate", 8'h00, t, 1'b0, 1'b1);
    end
    step("t2_grant", 8'h80, 8'h80, 1'b0, 1'b1);
    arb_if.Request_In = 8'h00;
    step("t2_gap",   8'h00, 8'h80, 1'b0, 1'b1);
    step("t2_wrap",  8'h00, 8'h01, 1'b0, 1'b1);

    // Slot limit of 4 ends a held grant with a single timeout pulse.
    do_reset();
    arb_if.Slot_Limit_In = 8'd4;
    arb_if.Request_In    = 8'h04;
    do_start();
    step("t3_rot1", 8'h00, 8'h02, 1'b0, 1'b1);
    step("t3_rot2", 8'h00, 8'h04, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("t3_grant", 8'h04, 8'h04, 1'b0, 1'b1);
    step("t3_timeout", 8'h00, 8'h04, 1'b1, 1'b1);
    step("t3_scan",    8'h00, 8'h08, 1'b0, 1'b1);
    step("t3_rot3",    8'h00, 8'h10, 1'b0, 1'b1);

    // All requesting, limit 2: round robin, never the same requester twice in a row.
    do_reset();
    arb_if.Slot_Limit_In = 8'd2;
    arb_if.Request_In    = 8'hFF;
    do_start();
    t = 8'h01;
    for (int k = 0; k < 9; k++) begin
      step("t4_grant_a", t, t, 1'b0, 1'b1);
      step("t4_grant_b", t, t, 1'b0, 1'b1);
      step("t4_gap",     8'h00, t, 1'b1, 1'b1);
      step("t4_scan",    8'h00, rotl(t), 1'b0, 1'b1);
      t = rotl(t);
    end

    // Release coinciding with the limit: no timeout pulse.
    do_reset();
    arb_if.Slot_Limit_In = 8'd2;
    arb_if.Request_In    = 8'h01;
    do_start();
    step("t6_grant1", 8'h01, 8'h01, 1'b0, 1'b1);
    step("t6_grant2", 8'h01, 8'h01, 1'b0, 1'b1);
    arb_if.Request_In = 8'h00;
    step("t6_gap",    8'h00, 8'h01, 1'b0, 1'b1);
    step("t6_scan",   8'h00, 8'h02, 1'b0, 1'b1);

    // Graceful stop mid-grant, unlimited slot; then Start+Stop together, then Stop in SCAN.
    do_reset();
    arb_if.Slot_Limit_In = 8'd0;
    arb_if.Request_In    = 8'h01;
    do_start();
    step("t5_grant", 8'h01, 8'h01, 1'b0, 1'b1);
    arb_if.Stop_Arbiter_Command_In = 1'b1;
    step("t5_stop",  8'h01, 8'h01, 1'b0, 1'b0);
    arb_if.Stop_Arbiter_Command_In = 1'b0;
    step("t5_hold",  8'h01, 8'h01, 1'b0, 1'b0);
    arb_if.Request_In = 8'h00;
    step("t5_gap",   8'h00, 8'h01, 1'b0, 1'b0);
    step("t5_idle",  8'h00, 8'h02, 1'b0, 1'b0);
    step("t5_idle2", 8'h00, 8'h02, 1'b0, 1'b0);
    arb_if.Start_Arbiter_Command_In = 1'b1;
    arb_if.Stop_Arbiter_Command_In  = 1'b1;
    step("t5_both",  8'h00, 8'h02, 1'b0, 1'b1);
    arb_if.Start_Arbiter_Command_In = 1'b0;
    arb_if.Stop_Arbiter_Command_In  = 1'b0;
    step("t5_scan",  8'h00, 8'h02, 1'b0, 1'b1);
    arb_if.Stop_Arbiter_Command_In = 1'b1;
    step("t5_scan_stop", 8'h00, 8'h02, 1'b0, 1'b0);
    arb_if.Stop_Arbiter_Command_In = 1'b0;
    step("t5_idle3", 8'h00, 8'h02, 1'b0, 1'b0);

    // Asynchronous reset mid-grant.
    do_reset();
    arb_if.Request_In = 8'h08;
    do_start();
    step("t7_rot1",  8'h00, 8'h02, 1'b0, 1'b1);
    step("t7_rot2",  8'h00, 8'h04, 1'b0, 1'b1);
    step("t7_rot3",  8'h00, 8'h08, 1'b0, 1'b1);
    step("t7_grant", 8'h08, 8'h08, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check_vec("t7_rst.grant", 32'(grant_w), 32'h00);
    check_vec("t7_rst.token", 32'(token_w), 32'h01);
    check_vec("t7_rst.run",   32'(run_w),   32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Outputs released while disabled; state keeps moving to GRANT underneath.
    arb_if.Request_In = 8'h01;
    arb_if.Enable_In  = 1'b0;
    arb_if.Start_Arbiter_Command_In = 1'b1;
    @(posedge clk);
    #1;
    arb_if.Start_Arbiter_Command_In = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check_vec("t8_hiz.grant", 32'(is_hiz8(grant_w)), 32'h1);
    check_vec("t8_hiz.token", 32'(is_hiz8(token_w)), 32'h1);
    check_vec("t8_hiz.run",   32'((run_w === 1'bz) || (run_w === 1'b0)), 32'h1);
    arb_if.Enable_In = 1'b1;
    #1;
    check_vec("t8_en.grant", 32'(grant_w), 32'h01);
    check_vec("t8_en.run",   32'(run_w),   32'h1);

    if (exp_q.size() != 0) begin
      check_vec("sb_drain", 32'(exp_q.size()), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
